// File: rtl/vga_overlay_mixer.sv
// Merges a background pixel stream with a sprite stream into one registered pixel stream.
// Define VGA_OVERLAY_MIXER_DROP_CNT_EN to add the drop_count output (discarded-beat counter).
module vga_overlay_mixer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    EMPTY_WIDTH = $clog2(DATA_WIDTH/8+1),
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   bg_ready,
    input  logic [DATA_WIDTH-1:0]  bg_data,
    input  logic                   bg_sop,
    input  logic                   bg_eop,
    input  logic [EMPTY_WIDTH-1:0] bg_empty,
    input  logic                   bg_valid,
    output logic                   spr_ready,
    input  logic [DATA_WIDTH-1:0]  spr_data,
    input  logic                   spr_sop,
    input  logic                   spr_eop,
    input  logic [EMPTY_WIDTH-1:0] spr_empty,
    input  logic                   spr_valid,
    input  logic                   st_ready,
    output logic [DATA_WIDTH-1:0]  st_data,
    output logic                   st_sop,
    output logic                   st_eop,
    output logic [EMPTY_WIDTH-1:0] st_empty,
    output logic                   st_valid
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam logic [1:0] S_SYNC      = 2'd0;
    localparam logic [1:0] S_MIX       = 2'd1;
    localparam logic [1:0] S_DRAIN_BG  = 2'd2;
    localparam logic [1:0] S_DRAIN_SPR = 2'd3;

    localparam logic [EMPTY_WIDTH-1:0] EMPTY_FULL = EMPTY_WIDTH'(DATA_WIDTH/8);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_st_valid;
    logic [DATA_WIDTH-1:0]  r_st_data;
    logic                   r_st_sop;
    logic                   r_st_eop;
    logic [EMPTY_WIDTH-1:0] r_st_empty;

    logic                   w_load_ok;
    logic                   w_bg_hold;
    logic                   w_spr_hold;
    logic                   w_pair;
    logic [DATA_WIDTH-1:0]  w_mix_data;
    logic                   w_bg_rdy;
    logic                   w_spr_rdy;
    logic                   w_load;
    logic [DATA_WIDTH-1:0]  w_out_data;
    logic                   w_out_sop;
    logic                   w_out_eop;
    logic [EMPTY_WIDTH-1:0] w_out_empty;
    logic                   w_unused_spr_empty;

    // The closing beat's empty is taken from the background side only.
    assign w_unused_spr_empty = &{1'b0, spr_empty};

    assign w_load_ok  = !r_st_valid || st_ready;
    assign w_bg_hold  = bg_valid && bg_sop && !bg_eop;
    assign w_spr_hold = spr_valid && spr_sop && !spr_eop;
    assign w_pair     = bg_valid && spr_valid && w_load_ok;
    assign w_mix_data = (spr_data == TRANSPARENT) ? bg_data : spr_data;

    always_comb begin
        w_bg_rdy     = 1'b0;
        w_spr_rdy    = 1'b0;
        w_state_next = r_state;
        w_load       = 1'b0;
        w_out_data   = '0;
        w_out_sop    = 1'b0;
        w_out_eop    = 1'b0;
        w_out_empty  = '0;
        case (r_state)
            S_SYNC: begin
                // A sink stops accepting once it presents a real SOP, parking that beat.
                w_bg_rdy  = !w_bg_hold;
                w_spr_rdy = !w_spr_hold;
                if (w_bg_hold && w_spr_hold) begin
                    w_state_next = S_MIX;
                end
            end
            S_MIX: begin
                if (w_pair) begin
                    w_load = 1'b1;
                    case ({bg_eop, spr_eop})
                        2'b00: begin
                            w_bg_rdy   = 1'b1;
                            w_spr_rdy  = 1'b1;
                            w_out_data = w_mix_data;
                            w_out_sop  = bg_sop;
                        end
                        2'b11: begin
                            w_bg_rdy     = 1'b1;
                            w_spr_rdy    = 1'b1;
                            w_out_eop    = 1'b1;
                            w_out_empty  = bg_empty;
                            w_state_next = S_SYNC;
                        end
                        2'b10: begin
                            w_bg_rdy     = 1'b1;
                            w_out_eop    = 1'b1;
                            w_out_empty  = EMPTY_FULL;
                            w_state_next = S_DRAIN_SPR;
                        end
                        default: begin
                            w_spr_rdy    = 1'b1;
                            w_out_eop    = 1'b1;
                            w_out_empty  = EMPTY_FULL;
                            w_state_next = S_DRAIN_BG;
                        end
                    endcase
                end
            end
            S_DRAIN_BG: begin
                w_bg_rdy = 1'b1;
                if (bg_valid && bg_eop) begin
                    w_state_next = S_SYNC;
                end
            end
            default: begin
                w_spr_rdy = 1'b1;
                if (spr_valid && spr_eop) begin
                    w_state_next = S_SYNC;
                end
            end
        endcase
    end

    assign bg_ready  = w_bg_rdy && !reset;
    assign spr_ready = w_spr_rdy && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_SYNC;
            r_st_valid <= 1'b0;
            r_st_data  <= '0;
            r_st_sop   <= 1'b0;
            r_st_eop   <= 1'b0;
            r_st_empty <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_ok) begin
                r_st_valid <= w_load;
                if (w_load) begin
                    r_st_data  <= w_out_data;
                    r_st_sop   <= w_out_sop;
                    r_st_eop   <= w_out_eop;
                    r_st_empty <= w_out_empty;
                end
            end
        end
    end

    assign st_valid = r_st_valid;
    assign st_data  = r_st_data;
    assign st_sop   = r_st_sop;
    assign st_eop   = r_st_eop;
    assign st_empty = r_st_empty;

`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
    logic        w_drop_bg;
    logic        w_drop_spr;
    logic [16:0] w_drop_sum;
    logic [15:0] r_drop_count;

    assign w_drop_bg  = bg_valid && bg_ready && (r_state == S_SYNC || r_state == S_DRAIN_BG);
    assign w_drop_spr = spr_valid && spr_ready && (r_state == S_SYNC || r_state == S_DRAIN_SPR);
    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_bg) + 17'(w_drop_spr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_vga_overlay_mixer.sv
// Randomized bench for vga_overlay_mixer: packet-level reference model plus a per-cycle compare process.
// A second instance with TRANSPARENT=1 shares all inputs and is checked against the same model.
module tb_vga_overlay_mixer;
    localparam int DW = 32;
    localparam int EW = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } obeat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          bg_ready, bg_sop, bg_eop, bg_valid;
    logic [DW-1:0] bg_data;
    logic [EW-1:0] bg_empty;
    logic          spr_ready, spr_sop, spr_eop, spr_valid;
    logic [DW-1:0] spr_data;
    logic [EW-1:0] spr_empty;
    logic          st_ready;
    logic [DW-1:0] st_data, t1_data;
    logic          st_sop, st_eop, st_valid, t1_sop, t1_eop, t1_valid;
    logic [EW-1:0] st_empty, t1_empty;
    logic          unused_t1_bg_ready, unused_t1_spr_ready;
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
    logic [15:0]   drop_count, unused_t1_drop_count;
`endif

    vga_overlay_mixer u_dut (
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .clk(clk), .reset(reset),
        .bg_ready(bg_ready), .bg_data(bg_data), .bg_sop(bg_sop), .bg_eop(bg_eop),
        .bg_empty(bg_empty), .bg_valid(bg_valid),
        .spr_ready(spr_ready), .spr_data(spr_data), .spr_sop(spr_sop), .spr_eop(spr_eop),
        .spr_empty(spr_empty), .spr_valid(spr_valid),
        .st_ready(st_ready), .st_data(st_data), .st_sop(st_sop), .st_eop(st_eop),
        .st_empty(st_empty), .st_valid(st_valid)
    );

    vga_overlay_mixer #(.TRANSPARENT(32'h1)) u_dut_t1 (
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
        .drop_count(unused_t1_drop_count),
`endif
        .clk(clk), .reset(reset),
        .bg_ready(unused_t1_bg_ready), .bg_data(bg_data), .bg_sop(bg_sop), .bg_eop(bg_eop),
        .bg_empty(bg_empty), .bg_valid(bg_valid),
        .spr_ready(unused_t1_spr_ready), .spr_data(spr_data), .spr_sop(spr_sop), .spr_eop(spr_eop),
        .spr_empty(spr_empty), .spr_valid(spr_valid),
        .st_ready(st_ready), .st_data(t1_data), .st_sop(t1_sop), .st_eop(t1_eop),
        .st_empty(t1_empty), .st_valid(t1_valid)
    );

    beat_t  bg_q[$];
    beat_t  spr_q[$];
    obeat_t exp_q[$];
    obeat_t out_log[$];
    int     bi, si;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     model_drops;
    bit     chk_en = 1'b0;

    // Packet-level reference: walks both beat lists applying the alignment/mix rules.
    task automatic run_model(input int b0, input int s0);
        int     b = b0;
        int     s = s0;
        bit     done = 1'b0;
        obeat_t o;
        exp_q.delete();
        model_drops = 0;
        while (!done) begin
            while (b < bg_q.size() && !(bg_q[b].sop && !bg_q[b].eop)) begin b++; model_drops++; end
            while (s < spr_q.size() && !(spr_q[s].sop && !spr_q[s].eop)) begin s++; model_drops++; end
            if (b >= bg_q.size() || s >= spr_q.size()) begin
                done = 1'b1;
            end else begin
                while (1) begin
                    if (b >= bg_q.size() || s >= spr_q.size()) begin done = 1'b1; break; end
                    o.sop = 1'b0; o.eop = 1'b1; o.d0 = '0; o.d1 = '0; o.empty = EW'(4);
                    if (!bg_q[b].eop && !spr_q[s].eop) begin
                        o.d0 = (spr_q[s].data == 32'h0) ? bg_q[b].data : spr_q[s].data;
                        o.d1 = (spr_q[s].data == 32'h1) ? bg_q[b].data : spr_q[s].data;
                        o.sop = bg_q[b].sop; o.eop = 1'b0; o.empty = '0;
                        exp_q.push_back(o); b++; s++;
                    end else if (bg_q[b].eop && spr_q[s].eop) begin
                        o.empty = bg_q[b].empty;
                        exp_q.push_back(o); b++; s++;
                        break;
                    end else if (bg_q[b].eop) begin
                        exp_q.push_back(o); b++;
                        while (s < spr_q.size()) begin model_drops++; s++; if (spr_q[s-1].eop) break; end
                        break;
                    end else begin
                        exp_q.push_back(o); s++;
                        while (b < bg_q.size()) begin model_drops++; b++; if (bg_q[b-1].eop) break; end
                        break;
                    end
                end
            end
        end
    endtask

    logic          have_prev = 1'b0;
    logic          prev_v, prev_r, prev_sop, prev_eop;
    logic [DW-1:0] prev_d;
    logic [EW-1:0] prev_empty;
    obeat_t        e;

    always @(negedge clk) begin
        if (reset || !chk_en) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_v && !prev_r) begin
                n_cmp++;
                if (!(st_valid && st_data == prev_d && st_sop == prev_sop && st_eop == prev_eop && st_empty == prev_empty)) begin
                    n_bad++;
                    $display("FAIL hold: got v=%b d=%h sop=%b eop=%b empty=%0d, want v=1 d=%h sop=%b eop=%b empty=%0d",
                             st_valid, st_data, st_sop, st_eop, st_empty, prev_d, prev_sop, prev_eop, prev_empty);
                end
            end
            if (st_valid && st_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat: got d=%h sop=%b eop=%b, want no beat", st_data, st_sop, st_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (st_data !== e.d0 || st_sop !== e.sop || st_eop !== e.eop || st_empty !== e.empty ||
                        t1_valid !== 1'b1 || t1_data !== e.d1 || t1_sop !== e.sop || t1_eop !== e.eop || t1_empty !== e.empty) begin
                        n_bad++;
                        $display("FAIL beat: got d=%h/%h sop=%b eop=%b empty=%0d, want d=%h/%h sop=%b eop=%b empty=%0d",
                                 st_data, t1_data, st_sop, st_eop, st_empty, e.d0, e.d1, e.sop, e.eop, e.empty);
                    end
                end
                out_log.push_back('{st_data, t1_data, st_sop, st_eop, st_empty});
            end
            have_prev = 1'b1;
            prev_v = st_valid; prev_r = st_ready; prev_d = st_data;
            prev_sop = st_sop; prev_eop = st_eop; prev_empty = st_empty;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic add_frame(input int base, input int nbg, input int nspr, input int ff_idx,
                             input logic [DW-1:0] fill, input logic [EW-1:0] bg_eop_empty);
        for (int i = 0; i < nbg; i++) bg_q.push_back('{DW'(base + i), (i == 0), 1'b0, '0});
        bg_q.push_back('{'0, 1'b0, 1'b1, bg_eop_empty});
        for (int i = 0; i < nspr; i++) spr_q.push_back('{(i == ff_idx) ? 32'hFF : fill, (i == 0), 1'b0, '0});
        spr_q.push_back('{'0, 1'b0, 1'b1, EW'(4)});
    endtask

    task automatic gen_side(input bit is_spr, input int npix);
        beat_t b;
        int    nj;
        int    k;
        int    r;
        nj = int'($urandom_range(2));
        for (int j = 0; j < nj; j++) begin
            k = int'($urandom_range(2));
            b.data = $urandom; b.sop = (k == 2); b.eop = (k >= 1); b.empty = EW'($urandom_range(4));
            if (is_spr) spr_q.push_back(b); else bg_q.push_back(b);
        end
        for (int i = 0; i < npix; i++) begin
            r = int'($urandom_range(9));
            b.data = !is_spr ? $urandom : (r < 5) ? 32'h0 : (r < 7) ? 32'h1 : $urandom;
            b.sop = (i == 0) || ($urandom_range(7) == 0); b.eop = 1'b0; b.empty = '0;
            if (is_spr) spr_q.push_back(b); else bg_q.push_back(b);
        end
        b.data = $urandom; b.sop = 1'b0; b.eop = 1'b1; b.empty = EW'($urandom_range(4));
        if (is_spr) spr_q.push_back(b); else bg_q.push_back(b);
    endtask

    task automatic drive_inputs(input bit bacc, input bit sacc, input int rmode, input int vprob);
        if (bacc) bi++;
        if (sacc) si++;
        if (!(bg_valid && !bacc)) begin
            if (bi < bg_q.size() && int'($urandom_range(99)) < vprob) begin
                bg_valid = 1'b1; bg_data = bg_q[bi].data; bg_sop = bg_q[bi].sop;
                bg_eop = bg_q[bi].eop; bg_empty = bg_q[bi].empty;
            end else begin
                bg_valid = 1'b0; bg_data = $urandom; bg_sop = 1'($urandom); bg_eop = 1'($urandom);
                bg_empty = EW'($urandom);
            end
        end
        if (!(spr_valid && !sacc)) begin
            if (si < spr_q.size() && int'($urandom_range(99)) < vprob) begin
                spr_valid = 1'b1; spr_data = spr_q[si].data; spr_sop = spr_q[si].sop;
                spr_eop = spr_q[si].eop; spr_empty = spr_q[si].empty;
            end else begin
                spr_valid = 1'b0; spr_data = $urandom; spr_sop = 1'($urandom); spr_eop = 1'($urandom);
                spr_empty = EW'($urandom);
            end
        end
        if (rmode == 0) st_ready = 1'b1;
        else if (rmode == 1) st_ready = !st_ready;
        else st_ready = (int'($urandom_range(99)) < 60);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; chk_en = 1'b0;
        bg_valid = 1'b1; bg_sop = 1'b0; bg_eop = 1'b0;
        spr_valid = 1'b1; spr_sop = 1'b0; spr_eop = 1'b0; st_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(st_valid), 32'h0);
        check("rst_ready", 32'({bg_ready, spr_ready}), 32'h0);
        check("rst_ctrl", 32'({st_sop, st_eop, st_empty}), 32'h0);
        check("rst_data", st_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; bg_valid = 1'b0; spr_valid = 1'b0;
    endtask

    task automatic run_stream(input string nm, input int rmode, input int vprob, input bit rst_test);
        int cyc = 0;
        int idle = 0;
        int rph = 0;
        bit bacc, sacc, trig;
        apply_reset();
        bi = 0; si = 0;
        run_model(0, 0);
        out_log.delete();
        chk_en = 1'b1;
        drive_inputs(1'b0, 1'b0, rmode, vprob);
        while (idle < 12) begin
            @(negedge clk);
            bacc = bg_valid && bg_ready;
            sacc = spr_valid && spr_ready;
            trig = rst_test && rph == 0 && st_valid && !st_eop && st_data == 32'h2;
            if (rph == 1) check("rst_mid_ready", 32'({bg_ready, spr_ready}), 32'h0);
            if (rph == 2) begin check("rst_mid_valid", 32'(st_valid), 32'h0); rph = 3; end
            @(posedge clk); #1;
            if (trig) begin reset = 1'b1; rph = 1; end
            else if (rph == 1) begin reset = 1'b0; rph = 2; end
            drive_inputs(bacc, sacc, rmode, vprob);
            if (rph == 2) begin run_model(bi, si); out_log.delete(); end
            cyc++;
            if (exp_q.size() == 0 && bi == bg_q.size() && si == spr_q.size() && rph != 1) idle++;
            else idle = 0;
            if (cyc > 4000) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout %s: got %0d beats left, want 0", nm, exp_q.size());
                break;
            end
        end
        chk_en = 1'b0;
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
        check({nm, "_drops"}, 32'(drop_count), 32'(model_drops));
`endif
        $display("test %s: %0d beats out, %0d compared, %0d mismatched so far", nm, out_log.size(), n_cmp, n_bad);
    endtask

    initial begin
        reset = 1'b1; st_ready = 1'b0;
        bg_valid = 1'b0; bg_data = '0; bg_sop = 1'b0; bg_eop = 1'b0; bg_empty = '0;
        spr_valid = 1'b0; spr_data = '0; spr_sop = 1'b0; spr_eop = 1'b0; spr_empty = '0;

        bg_q.delete(); spr_q.delete();
        add_frame(0, 8, 8, 5, 32'h0, EW'(4));
        run_stream("aligned", 0, 100, 1'b0);
        check("aligned_count", 32'(out_log.size()), 32'd9);
        check("aligned_sop0", 32'(out_log[0].sop), 32'h1);
        check("aligned_px3", out_log[3].d0, 32'h3);
        check("aligned_px5", out_log[5].d0, 32'hFF);
        check("aligned_close", 32'({out_log[8].eop, out_log[8].empty}), 32'({1'b1, 3'd4}));

        run_stream("backpressure", 1, 100, 1'b0);
        check("bp_count", 32'(out_log.size()), 32'd9);
        check("bp_px5", out_log[5].d0, 32'hFF);

        bg_q.delete(); spr_q.delete();
        for (int j = 0; j < 3; j++) spr_q.push_back('{32'h7, 1'b0, 1'b0, '0});
        add_frame(0, 8, 8, 5, 32'h0, EW'(4));
        run_stream("junk", 2, 80, 1'b0);
        check("junk_count", 32'(out_log.size()), 32'd9);
        check("junk_px5", out_log[5].d0, 32'hFF);
`ifdef VGA_OVERLAY_MIXER_DROP_CNT_EN
        check("junk_drop3", 32'(drop_count), 32'd3);
`endif

        bg_q.delete(); spr_q.delete();
        add_frame(0, 8, 4, 2, 32'h0, EW'(2));
        add_frame(100, 8, 8, 5, 32'h0, EW'(4));
        run_stream("spr_early_eop", 2, 80, 1'b0);
        check("early_count", 32'(out_log.size()), 32'd14);
        check("early_px2", out_log[2].d0, 32'hFF);
        check("early_eop", 32'({out_log[4].eop, out_log[4].empty}), 32'({1'b1, 3'd4}));
        check("early_next_sop", 32'({out_log[5].sop, out_log[5].d0[7:0]}), 32'({1'b1, 8'd100}));

        bg_q.delete(); spr_q.delete();
        add_frame(0, 8, 8, 5, 32'h0, EW'(4));
        add_frame(100, 8, 8, 5, 32'h0, EW'(4));
        run_stream("reset_mid", 0, 100, 1'b1);
        check("rst_frame_count", 32'(out_log.size()), 32'd9);
        check("rst_frame_first", out_log[0].d0, 32'd100);

        bg_q.delete(); spr_q.delete();
        add_frame(0, 8, 8, -1, 32'h1, EW'(4));
        run_stream("transparent1", 2, 90, 1'b0);
        check("t1_px3", out_log[3].d1, 32'h3);
        check("t1_px6", out_log[6].d1, 32'h6);
        check("t0_px3", out_log[3].d0, 32'h1);

        for (int t = 0; t < 8; t++) begin
            bg_q.delete(); spr_q.delete();
            for (int p = 0; p < 3 + int'($urandom_range(2)); p++) begin
                gen_side(1'b0, 1 + int'($urandom_range(5)));
                gen_side(1'b1, 1 + int'($urandom_range(5)));
            end
            run_stream($sformatf("random%0d", t), 2, 50 + int'($urandom_range(40)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
